// File: rtl/tc_sm_pkg.sv
// Shared constants and helpers for the two's-complement to sign-magnitude stream.
// Contents: saturation-mode constants, most-negative-value helper.
// Latency: n/a (package). Backpressure: n/a.
package tc_sm_pkg;

  // Handling of the most-negative input.
  localparam int SM_SAT_CLAMP = 1;  // clamp magnitude to 2^(W-1)-1, flag sat
  localparam int SM_SAT_EXACT = 0;  // emit exact magnitude 2^(W-1)

  localparam int SM_MAX_W = 64;

  // Bit pattern of the most-negative two's-complement value of 'width' bits
  // (MSB set, rest clear), zero-extended to SM_MAX_W.
  function automatic logic [SM_MAX_W-1:0] min_value(input int width);
    return SM_MAX_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/tc_to_sm_stream_if.sv
// Stream bundle for tc_to_sm_stream: input beat channel and output beat channel.
// Ports: in_valid/in_ready/in_data upstream; out_valid/out_ready/out_sign/out_mag/out_sat downstream.
// Modports: slave = the converter's view, master = the driver/monitor's view.
interface tc_to_sm_stream_if #(
  parameter int WIDTH = 12,
  parameter int LANES = 1
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*WIDTH-1:0] in_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES-1:0]       out_sign;
  logic [LANES*WIDTH-1:0] out_mag;
  logic [LANES-1:0]       out_sat;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_mag, out_sat
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_mag, out_sat
  );
endinterface

// File: rtl/tc_sm_lane.sv
// Purpose: combinational two's-complement to sign-magnitude for one lane.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; ports d/is_min in, sign/mag/sat out.
module tc_sm_lane
  import tc_sm_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int SAT_MODE = SM_SAT_CLAMP
) (
  input  logic [WIDTH-1:0] d,
  input  logic             is_min,  // d == most-negative value, precomputed upstream
  output logic             sign,
  output logic [WIDTH-1:0] mag,
  output logic             sat
);
  localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(min_value(WIDTH));
  localparam logic [WIDTH-1:0] MAX_POS = MIN_VAL - 1'b1;

  always_comb begin
    sign = d[WIDTH-1];
    mag  = d;
    sat  = 1'b0;
    if (d[WIDTH-1]) begin
      if (is_min && (SAT_MODE == SM_SAT_CLAMP)) begin
        mag = MAX_POS;
        sat = 1'b1;
      end else begin
        // For the exact mode the negation of min wraps back to 2^(W-1),
        // which read as unsigned is exactly the required magnitude.
        mag = ~d + 1'b1;
      end
    end
  end
endmodule

// File: rtl/tc_to_sm_stream.sv
// Purpose: LANES x WIDTH two's-complement to sign+magnitude stream converter (clk, rst_n, bus slave).
// Latency: 2 cycles (S1 input register, S2 output register); 1 beat/cycle with out_ready high.
// Backpressure: valid/ready, in_ready combinational from out_ready; holds up to 2 beats.
// Optional TC_TO_SM_SAT_COUNT_EN adds sat_clr input and per-lane saturating sat_count output.
module tc_to_sm_stream
  import tc_sm_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int LANES    = 1,
  parameter int SAT_MODE = SM_SAT_CLAMP,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  tc_to_sm_stream_if.slave         bus
`ifdef TC_TO_SM_SAT_COUNT_EN
  ,
  input  logic                     sat_clr,
  output logic [LANES*CNT_W-1:0]   sat_count
`endif
);
  // Lane record held in S2. Its magnitude width follows WIDTH, so it is
  // declared here where the parameter is known.
  typedef struct packed {
    logic             sign;
    logic             sat;
    logic [WIDTH-1:0] mag;
  } lane_rec_t;

  localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(min_value(WIDTH));

  logic                   s1_valid_q, s1_valid_d;
  logic [LANES*WIDTH-1:0] s1_data_q, s1_data_d;   // raw lanes; sign is each lane's MSB
  logic [LANES-1:0]       s1_min_q, s1_min_d;
  logic                   s2_valid_q, s2_valid_d;
  lane_rec_t [LANES-1:0]  s2_rec_q, s2_rec_d;

  logic                   s1_adv, s2_adv, in_fire;
  logic [LANES-1:0]       lane_sign, lane_sat;
  logic [LANES*WIDTH-1:0] lane_mag;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    tc_sm_lane #(.WIDTH(WIDTH), .SAT_MODE(SAT_MODE)) u_lane (
      .d      (s1_data_q[i*WIDTH +: WIDTH]),
      .is_min (s1_min_q[i]),
      .sign   (lane_sign[i]),
      .mag    (lane_mag[i*WIDTH +: WIDTH]),
      .sat    (lane_sat[i])
    );

    assign bus.out_sign[i]              = s2_rec_q[i].sign;
    assign bus.out_sat[i]               = s2_rec_q[i].sat;
    assign bus.out_mag[i*WIDTH +: WIDTH] = s2_rec_q[i].mag;
  end

  always_comb begin
    s2_adv  = ~s2_valid_q | bus.out_ready;
    s1_adv  = ~s1_valid_q | s2_adv;
    in_fire = bus.in_valid & s1_adv;

    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_min_d   = s1_min_q;
    if (s1_adv) s1_valid_d = bus.in_valid;  // fill, or empty when nothing arrives
    if (in_fire) begin
      s1_data_d = bus.in_data;
      for (int i = 0; i < LANES; i++)
        s1_min_d[i] = (bus.in_data[i*WIDTH +: WIDTH] == MIN_VAL);
    end

    s2_valid_d = s2_valid_q;
    s2_rec_d   = s2_rec_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      // Payload only moves with a real beat so idle outputs keep last value.
      if (s1_valid_q) begin
        for (int i = 0; i < LANES; i++)
          s2_rec_d[i] = '{sign: lane_sign[i], sat: lane_sat[i],
                          mag: lane_mag[i*WIDTH +: WIDTH]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_min_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_rec_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_min_q   <= s1_min_d;
      s2_valid_q <= s2_valid_d;
      s2_rec_q   <= s2_rec_d;
    end
  end

  assign bus.in_ready  = s1_adv;
  assign bus.out_valid = s2_valid_q;

`ifdef TC_TO_SM_SAT_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [LANES*CNT_W-1:0] sat_count_q, sat_count_d;

  always_comb begin
    sat_count_d = sat_count_q;
    for (int i = 0; i < LANES; i++) begin
      if (sat_clr)
        sat_count_d[i*CNT_W +: CNT_W] = '0;  // clear wins over a same-cycle hit
      else if (s2_valid_q && bus.out_ready && s2_rec_q[i].sat &&
               (sat_count_q[i*CNT_W +: CNT_W] != CNT_MAX))
        sat_count_d[i*CNT_W +: CNT_W] = sat_count_q[i*CNT_W +: CNT_W] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_count_q <= '0;
    else        sat_count_q <= sat_count_d;
  end

  assign sat_count = sat_count_q;
`endif
endmodule
